// File: rtl/matrix_alu_pkg.sv
// matrix_alu_pkg: opcode constants, FSM states and product-sequence lengths for matrix_alu
package matrix_alu_pkg;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00100;
    localparam logic [4:0] OP_TRAN = 5'b01000;
    localparam logic [4:0] OP_DET  = 5'b10000;
    localparam int MUL_LEN = 8;
    localparam int DET_LEN = 2;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;
    function automatic logic op_legal(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_TRAN, OP_DET};
    endfunction
endpackage

// File: rtl/matrix_alu_mac.sv
// matrix_alu_mac: shared multiplier feeding a signed accumulator with clear/add/subtract control
module matrix_alu_mac #(
    parameter int DATA_W = 7,
    parameter int ACC_W = 2 * DATA_W + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     sub,
    input  logic [DATA_W-1:0]        a,
    input  logic [DATA_W-1:0]        b,
    output logic signed [ACC_W-1:0] sum
);
    logic [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] base, acc_q, acc_d;
    always_comb begin
        prod = ACC_W'(a) * ACC_W'(b);
        base = clr ? '0 : acc_q;
        sum = sub ? base - $signed(prod) : base + $signed(prod);
        acc_d = en ? sum : acc_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) acc_q <= '0;
        else acc_q <= acc_d;
endmodule

// File: rtl/matrix_alu.sv
// matrix_alu: 2x2 matrix ALU (add/sub/mul/transpose/determinant) behind a valid/ready command interface
module matrix_alu
    import matrix_alu_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int SAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*DATA_W+4:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic                  out_err
);
    localparam int ACC_W = 2 * DATA_W + 2;
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8*DATA_W+4:0] cmd_q, cmd_d;
    logic [4*DATA_W-1:0] out_data_q, out_data_d;
    logic err_q, err_d;
    logic [DATA_W-1:0] a [4];
    logic [DATA_W-1:0] b [4];
    logic [4:0] op_q;
    logic last, mac_en, mac_clr, mac_sub;
    logic [DATA_W-1:0] mac_a, mac_b;
    logic signed [ACC_W-1:0] mac_sum;
    // Results are formed in ACC_W-bit two's complement, so the sign bit and upper bits decide clamping
    function automatic logic [DATA_W-1:0] fit(input logic [ACC_W-1:0] v);
        return (SAT == 0) ? v[DATA_W-1:0] :
               v[ACC_W-1] ? '0 : |v[ACC_W-2:DATA_W] ? '1 : v[DATA_W-1:0];
    endfunction
    for (genvar i = 0; i < 4; i++) begin : g_ops
        assign a[i] = cmd_q[i*DATA_W +: DATA_W];
        assign b[i] = cmd_q[(4+i)*DATA_W +: DATA_W];
    end
    assign op_q = cmd_q[8*DATA_W +: 5];
    assign last = (op_q == OP_MUL) ? cnt_q == CNT_W'(MUL_LEN - 1) :
                  (op_q == OP_DET) ? cnt_q == CNT_W'(DET_LEN - 1) : 1'b1;
    // MUL walks A0B0,A1B2,A0B1,A1B3,A2B0,A3B2,A2B1,A3B3; DET does A0*A3 then subtracts A1*A2
    assign mac_a = (op_q == OP_DET) ? (cnt_q[0] ? a[1] : a[0]) : a[{cnt_q[2], cnt_q[0]}];
    assign mac_b = (op_q == OP_DET) ? (cnt_q[0] ? a[2] : a[3]) : b[{cnt_q[0], cnt_q[1]}];
    assign mac_en = state_q == EXEC && (op_q == OP_MUL || op_q == OP_DET);
    assign mac_clr = !cnt_q[0];
    assign mac_sub = op_q == OP_DET && cnt_q[0];
    matrix_alu_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk(clk), .rst(rst), .en(mac_en), .clr(mac_clr), .sub(mac_sub),
        .a(mac_a), .b(mac_b), .sum(mac_sum)
    );
    always_comb begin
        state_d = state_q;
        cnt_d = '0;
        cmd_d = cmd_q;
        out_data_d = out_data_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                cmd_d = in_data;
                err_d = !op_legal(in_data[8*DATA_W +: 5]);
                state_d = op_legal(in_data[8*DATA_W +: 5]) ? EXEC : RESP;
                out_data_d = op_legal(in_data[8*DATA_W +: 5]) ? out_data_q : '0;
            end
            EXEC: begin
                cnt_d = last ? '0 : cnt_q + CNT_W'(1);
                state_d = last ? RESP : EXEC;
                for (int k = 0; k < 4; k++)
                    out_data_d[k*DATA_W +: DATA_W] =
                        (op_q == OP_MUL) ? ((cnt_q[0] && cnt_q[2:1] == 2'(k)) ? fit(mac_sum) : out_data_q[k*DATA_W +: DATA_W]) :
                        (op_q == OP_DET) ? ((k == 0 && last) ? fit(mac_sum) : '0) :
                        (op_q == OP_ADD) ? fit(ACC_W'(a[k]) + ACC_W'(b[k])) :
                        (op_q == OP_SUB) ? fit(ACC_W'(a[k]) - ACC_W'(b[k])) : a[{k[0], k[1]}];
            end
            RESP: state_d = out_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            cmd_q <= '0;
            out_data_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            cmd_q <= cmd_d;
            out_data_q <= out_data_d;
            err_q <= err_d;
        end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == RESP;
    assign out_data = out_data_q;
    assign out_err = err_q;
endmodule

// File: tb/tb_matrix_alu.sv
// tb_matrix_alu: directed vectors plus randomized commands against a plain-arithmetic matrix model, SAT=0 and SAT=1
module tb_matrix_alu;
    localparam int W = 7;
    localparam int MAXV = (1 << W) - 1;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [8*W+4:0] in_data = '0;
    logic in_ready0, in_ready1, out_valid0, out_valid1, out_err0, out_err1;
    logic [4*W-1:0] out_data0, out_data1;
    int checks = 0, failures = 0;

    typedef struct {
        logic [4:0]     op;
        logic [4*W-1:0] a, b, e0, e1;
        logic           err;
        int             lat;
        int             hold;
    } vec_t;

    always #5 clk = ~clk;

    matrix_alu #(.DATA_W(W), .SAT(0)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_err(out_err0)
    );
    matrix_alu #(.DATA_W(W), .SAT(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_err(out_err1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [4*W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
        return {W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    function automatic int clip(input int v, input bit sat);
        return sat ? (v < 0 ? 0 : (v > MAXV ? MAXV : v)) : (v & MAXV);
    endfunction

    function automatic bit legal(input logic [4:0] op);
        return op == 5'b00001 || op == 5'b00010 || op == 5'b00100 || op == 5'b01000 || op == 5'b10000;
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        return !legal(op) ? 1 : op == 5'b00100 ? 9 : op == 5'b10000 ? 3 : 2;
    endfunction

    // Treat A and B as 2x2 matrices [[x0,x1],[x2,x3]] and compute with integer arithmetic
    function automatic logic [4*W-1:0] model(input logic [4:0] op, input logic [4*W-1:0] a,
                                              input logic [4*W-1:0] b, input bit sat);
        int x[4], y[4], r[4];
        for (int i = 0; i < 4; i++) begin
            x[i] = int'(a[i*W +: W]);
            y[i] = int'(b[i*W +: W]);
            r[i] = 0;
        end
        case (op)
            5'b00001: for (int i = 0; i < 4; i++) r[i] = x[i] + y[i];
            5'b00010: for (int i = 0; i < 4; i++) r[i] = x[i] - y[i];
            5'b00100: begin
                r[0] = x[0] * y[0] + x[1] * y[2];
                r[1] = x[0] * y[1] + x[1] * y[3];
                r[2] = x[2] * y[0] + x[3] * y[2];
                r[3] = x[2] * y[1] + x[3] * y[3];
            end
            5'b01000: begin
                r[0] = x[0]; r[1] = x[2]; r[2] = x[1]; r[3] = x[3];
            end
            5'b10000: r[0] = x[0] * x[3] - x[1] * x[2];
            default: ;
        endcase
        return pk(clip(r[0], sat), clip(r[1], sat), clip(r[2], sat), clip(r[3], sat));
    endfunction

    task automatic run(input vec_t v);
        int lat;
        @(negedge clk);
        check("in_ready_idle", in_ready0, 1);
        in_valid = 1'b1;
        in_data = {v.op, v.b, v.a};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = ~in_data;
        lat = 1;
        while (!out_valid0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, v.lat);
        check("out_data_sat0", out_data0, v.e0);
        check("out_data_sat1", out_data1, v.e1);
        check("out_err_sat0", out_err0, v.err);
        check("out_err_sat1", out_err1, v.err);
        check("out_valid_sat1", out_valid1, 1);
        check("in_ready_busy", in_ready0, 0);
        repeat (v.hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid0, 1);
            check("hold_data", out_data0, v.e0);
            check("hold_in_ready", in_ready0, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", out_valid0, 0);
        check("post_in_ready", in_ready0, 1);
        check("post_data_kept", out_data0, v.e0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[8];
        vec_t v;
        int r;
        tv[0] = '{5'b00001, pk(1, 2, 3, 4), pk(10, 20, 30, 40), pk(11, 22, 33, 44), pk(11, 22, 33, 44), 1'b0, 2, 0};
        tv[1] = '{5'b00100, pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(19, 22, 43, 50), pk(19, 22, 43, 50), 1'b0, 9, 1};
        tv[2] = '{5'b00100, pk(100, 100, 100, 100), pk(100, 100, 100, 100), pk(32, 32, 32, 32), pk(127, 127, 127, 127), 1'b0, 9, 0};
        tv[3] = '{5'b10000, pk(5, 6, 7, 8), pk(0, 0, 0, 0), pk(126, 0, 0, 0), pk(0, 0, 0, 0), 1'b0, 3, 0};
        tv[4] = '{5'b00010, pk(3, 0, 0, 0), pk(5, 0, 0, 0), pk(126, 0, 0, 0), pk(0, 0, 0, 0), 1'b0, 2, 0};
        tv[5] = '{5'b00011, pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(0, 0, 0, 0), pk(0, 0, 0, 0), 1'b1, 1, 2};
        tv[6] = '{5'b01000, pk(1, 2, 3, 4), pk(9, 9, 9, 9), pk(1, 3, 2, 4), pk(1, 3, 2, 4), 1'b0, 2, 5};
        tv[7] = '{5'b00001, pk(100, 127, 0, 64), pk(100, 1, 0, 64), pk(72, 0, 0, 0), pk(127, 127, 0, 127), 1'b0, 2, 0};

        #12;
        check("reset_valid", out_valid0, 0);
        check("reset_data", out_data0, 0);
        check("reset_err", out_err0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready0, 1);

        for (int i = 0; i < 8; i++) run(tv[i]);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            v.op = (r < 5) ? 5'(1 << r) : 5'($urandom_range(0, 31));
            v.a = 28'($urandom);
            v.b = 28'($urandom);
            v.e0 = model(v.op, v.a, v.b, 1'b0);
            v.e1 = model(v.op, v.a, v.b, 1'b1);
            v.err = !legal(v.op);
            v.lat = lat_of(v.op);
            v.hold = $urandom_range(0, 2);
            run(v);
        end

        // Reset lands in the fourth MUL EXEC cycle, after element 0 has already been written
        @(negedge clk);
        in_valid = 1'b1;
        in_data = {5'b00100, pk(5, 6, 7, 8), pk(1, 2, 3, 4)};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid0, 0);
        check("midrst_data", out_data0, 0);
        check("midrst_err", out_err0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", in_ready0, 1);
        r = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            r += int'(out_valid0);
        end
        check("midrst_no_result", r, 0);
        check("midrst_data_after", out_data0, 0);
        run(tv[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
